// File: rtl/tile_bit_packer.sv
// tile_bit_packer
//
// Packs a TILE_SIZE x TILE_SIZE tile into a dense bitstream. The tile
// arrives one row per accepted i_valid/i_ready handshake. Each pixel's
// flag code selects a bit length from LEN_TABLE. That length is clamped to
// DATA_W. The low 'len' bits of the pixel's residual are appended LSB-first:
// pixel 0 of row 0 lands at bit 0.
//
// A completed tile is moved into an output register. That register is
// independent of the accumulator, so the next tile can build up while the
// consumer still holds the previous one.
//
// Optional feature macro: TBP_RAW_FIRST_EN
//   When defined, pixel 0 of row 0 of every tile is always packed with the
//   full DATA_W bits, so the tile anchor is raw.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   i_valid     row present
//   i_ready     row accepted when i_valid && i_ready (combinational)
//   i_data      pixel p residual at [p*DATA_W +: DATA_W]
//   i_flag      pixel p flag code at [p*FLAG_W +: FLAG_W]
//   i_abort     synchronously discard the partial tile (drops a same-cycle row)
//   o_valid     packed tile available
//   o_ready     consumer takes the tile when o_valid && o_ready
//   o_data      packed tile, bit 0 first, zero at and above o_bitsize
//   o_bitsize   total packed bits
//   o_bytesize  ceil(o_bitsize / 8)
module tile_bit_packer #(
    parameter int TILE_SIZE = 8,
    parameter int DATA_W    = 8,
    parameter int FLAG_W    = 3,
    parameter logic [4*(2**FLAG_W)-1:0] LEN_TABLE = 32'h8884_4220,
    localparam int TILE_BITS = DATA_W * TILE_SIZE * TILE_SIZE,
    localparam int BITS_W    = $clog2(TILE_BITS + 1),
    localparam int BYTES_W   = $clog2(TILE_BITS / 8 + 2)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          i_ready,
    input  logic [DATA_W*TILE_SIZE-1:0]   i_data,
    input  logic [FLAG_W*TILE_SIZE-1:0]   i_flag,
    input  logic                          i_abort,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [TILE_BITS-1:0]          o_data,
    output logic [BITS_W-1:0]             o_bitsize,
    output logic [BYTES_W-1:0]            o_bytesize
);

    localparam int ROW_W     = DATA_W * TILE_SIZE;
    localparam int ROW_LEN_W = $clog2(ROW_W + 1);
    localparam int CNT_W     = $clog2(TILE_SIZE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]     row_cnt_reg;
    logic [TILE_BITS-1:0] acc_reg;
    logic [BITS_W-1:0]    acc_bits_reg;

    logic                 o_valid_reg;
    logic [TILE_BITS-1:0] o_data_reg;
    logic [BITS_W-1:0]    o_bitsize_reg;
    logic [BYTES_W-1:0]   o_bytesize_reg;

    // ------------------------------------------------------------------
    // Per-pixel length lookup and masking
    // ------------------------------------------------------------------
    logic [ROW_LEN_W-1:0] pix_len    [TILE_SIZE];
    logic [DATA_W-1:0]    pix_masked [TILE_SIZE];

    generate
        for (genvar gi = 0; gi < TILE_SIZE; gi++) begin : g_pix
            logic [FLAG_W-1:0]    code;
            logic [3:0]           raw_len;
            logic [ROW_LEN_W-1:0] tab_len;
            logic [DATA_W-1:0]    mask;

            assign code    = i_flag[gi*FLAG_W +: FLAG_W];
            assign raw_len = LEN_TABLE[4*code +: 4];
            assign tab_len = (32'(raw_len) > DATA_W) ? ROW_LEN_W'(DATA_W)
                                                     : ROW_LEN_W'(raw_len);

            if (gi == 0) begin : g_first
`ifdef TBP_RAW_FIRST_EN
                // Tile anchor: first pixel of the first row is always raw.
                assign pix_len[gi] = (row_cnt_reg == '0) ? ROW_LEN_W'(DATA_W)
                                                         : tab_len;
`else
                assign pix_len[gi] = tab_len;
`endif
            end else begin : g_rest
                assign pix_len[gi] = tab_len;
            end

            // A shift by DATA_W yields zero, so len == DATA_W gives an all-ones mask.
            assign mask            = ~({DATA_W{1'b1}} << pix_len[gi]);
            assign pix_masked[gi]  = i_data[gi*DATA_W +: DATA_W] & mask;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Row packing: running prefix sum of the lengths places each pixel
    // ------------------------------------------------------------------
    logic [ROW_W-1:0]     row_bits;
    logic [ROW_LEN_W-1:0] row_len;

    always_comb begin
        row_bits = '0;
        row_len  = '0;
        for (int p = 0; p < TILE_SIZE; p++) begin
            row_bits = row_bits | (ROW_W'(pix_masked[p]) << row_len);
            row_len  = row_len + pix_len[p];
        end
    end

    // ------------------------------------------------------------------
    // Accumulator update and size arithmetic
    // ------------------------------------------------------------------
    logic [TILE_BITS-1:0] acc_next;
    logic [BITS_W-1:0]    acc_bits_next;
    logic [BITS_W+2:0]    bits_round;
    logic [BYTES_W-1:0]   bytes_next;

    assign acc_next      = acc_reg | (TILE_BITS'(row_bits) << acc_bits_reg);
    assign acc_bits_next = acc_bits_reg + BITS_W'(row_len);
    // Three extra bits keep the +7 rounding from wrapping for any size.
    assign bits_round    = {3'b000, acc_bits_next} + (BITS_W+3)'(7);
    assign bytes_next    = BYTES_W'(bits_round >> 3);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic last_row;
    logic accept;

    assign last_row = (row_cnt_reg == CNT_W'(TILE_SIZE - 1));
    // Stall only when this row would finish a tile while the previous tile
    // is still held and not being taken this cycle.
    assign i_ready  = !(last_row && o_valid_reg && !o_ready);
    assign accept   = i_valid && i_ready && !i_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt_reg    <= '0;
            acc_reg        <= '0;
            acc_bits_reg   <= '0;
            o_valid_reg    <= 1'b0;
            o_data_reg     <= '0;
            o_bitsize_reg  <= '0;
            o_bytesize_reg <= '0;
        end else begin
            if (i_abort || (accept && last_row)) begin
                row_cnt_reg  <= '0;
                acc_reg      <= '0;
                acc_bits_reg <= '0;
            end else if (accept) begin
                row_cnt_reg  <= row_cnt_reg + CNT_W'(1);
                acc_reg      <= acc_next;
                acc_bits_reg <= acc_bits_next;
            end

            // A completing tile replaces the held one even during a
            // same-edge handshake, so o_valid stays high in that case.
            if (accept && last_row) begin
                o_valid_reg    <= 1'b1;
                o_data_reg     <= acc_next;
                o_bitsize_reg  <= acc_bits_next;
                o_bytesize_reg <= bytes_next;
            end else if (o_ready) begin
                o_valid_reg    <= 1'b0;
            end
        end
    end

    assign o_valid    = o_valid_reg;
    assign o_data     = o_data_reg;
    assign o_bitsize  = o_bitsize_reg;
    assign o_bytesize = o_bytesize_reg;

endmodule
